// File: rtl/cpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_exec_ctrl
//
// Execution controller for the rv32i single-cycle core. It lives in the
// divided CPU clock domain (clk_out) and does the following:
//   - conditions the three raw board buttons (2-FF synchroniser, debounce
//     counter, rising-edge detector) into one-cycle press pulses;
//   - runs the HALT / RUN / STEP machine that gates the core's clock enable;
//   - halts on a single full-width PC breakpoint;
//   - counts executed (enabled) cycles for debug readout.
//
// Ports
//   clk_out      in   divided CPU clock
//   rst          in   asynchronous, active-low reset
//   btn_run      in   raw run button, active-high, asynchronous
//   btn_step     in   raw single-step button, active-high, asynchronous
//   btn_halt     in   raw halt button, active-high, asynchronous
//   bp_en        in   breakpoint enable (quasi-static)
//   bp_addr      in   breakpoint address [XLEN]
//   pc           in   current core PC [XLEN], same clock domain
//   cpu_en       out  core clock enable; an instruction retires on each
//                     clk_out edge where it is 1
//   state        out  00=HALT, 01=RUN, 10=STEP
//   bp_hit       out  sticky: the last entry to HALT came from the breakpoint
//   step_done    out  one-cycle pulse in the cycle a single step executes
//   cycle_count  out  number of clk_out edges with cpu_en=1 [CNT_W], wraps
// -----------------------------------------------------------------------------
module cpu_exec_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned XLEN            = 32
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_halt,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic [XLEN-1:0]  pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  // The counter toggles the level on the increment that would reach
  // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Button vectors are ordered {halt, step, run}.
  logic [2:0]       btn_raw_s;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       deb_q;
  logic [2:0]       deb_d;
  logic [2:0]       deb_prev_q;
  logic [2:0][15:0] cnt_q;
  logic [2:0][15:0] cnt_d;
  logic [2:0]       press_s;
  logic             run_p_s;
  logic             step_p_s;
  logic             halt_p_s;

  state_e           state_q;
  state_e           state_d;
  logic             bp_hit_q;
  logic             bp_hit_d;
  logic             bp_arm_q;
  logic             bp_arm_d;
  logic             bp_match_s;
  logic             cpu_en_s;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;

  assign btn_raw_s = {btn_halt, btn_step, btn_run};

  // Debounce next-state: count consecutive samples that disagree with the
  // debounced level; any agreeing sample restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int b = 0; b < 3; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        cnt_d[b] = 16'd0;
      end else if (cnt_q[b] == DB_LAST) begin
        deb_d[b] = ~deb_q[b];
        cnt_d[b] = 16'd0;
      end else begin
        cnt_d[b] = cnt_q[b] + 16'd1;
      end
    end
  end

  // Button synchroniser, debounce and edge-detect flops.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      deb_q      <= 3'b000;
      deb_prev_q <= 3'b000;
      cnt_q      <= {3{16'h0000}};
    end else begin
      sync1_q    <= btn_raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // Press pulse only on the debounced 0->1 transition; releases are silent.
  assign press_s  = deb_q & ~deb_prev_q;
  assign run_p_s  = press_s[0];
  assign step_p_s = press_s[1];
  assign halt_p_s = press_s[2];

  // bp_arm keeps a resumed RUN from re-halting on the breakpointed PC.
  assign bp_match_s = bp_en && bp_arm_q && (pc == bp_addr) && (state_q == ST_RUN);

  // A halt press or a breakpoint match blocks the instruction in this cycle.
  assign cpu_en_s = ((state_q == ST_RUN) && !bp_match_s && !halt_p_s) ||
                    (state_q == ST_STEP);

  // Execution state machine next-state, breakpoint flags and arm logic.
  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    bp_arm_d = bp_arm_q;
    case (state_q)
      ST_HALT: begin
        if (run_p_s) begin
          state_d  = ST_RUN;
          bp_hit_d = 1'b0;
        end else if (step_p_s) begin
          state_d  = ST_STEP;
          bp_hit_d = 1'b0;
        end else begin
          state_d  = ST_HALT;
        end
      end
      ST_RUN: begin
        if (halt_p_s) begin
          state_d  = ST_HALT;
        end else if (bp_match_s) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    // Disarm on entry to RUN, arm once a full RUN cycle has elapsed.
    if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
      bp_arm_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      bp_arm_d = 1'b1;
    end else begin
      bp_arm_d = bp_arm_q;
    end
  end

  // Executed-cycle counter next-state; wraps silently.
  always_comb begin
    if (cpu_en_s) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end else begin
      cycle_count_d = cycle_count_q;
    end
  end

  // Control state, breakpoint flags and cycle counter registers.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_HALT;
      bp_hit_q      <= 1'b0;
      bp_arm_q      <= 1'b0;
      cycle_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      bp_hit_q      <= bp_hit_d;
      bp_arm_q      <= bp_arm_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cpu_en      = cpu_en_s;
  assign state       = state_q;
  assign bp_hit      = bp_hit_q;
  assign step_done   = (state_q == ST_STEP);
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cpu_exec_ctrl. Two instances share all inputs: one with a
// 32-bit cycle counter and one with a 4-bit counter for wrap behaviour. A
// behavioural model (button history queues + rule-level state machine) gives
// the expected outputs of both every cycle.
// -----------------------------------------------------------------------------
module tb_cpu_exec_ctrl;

  localparam int D = 4;

  logic        clk_out = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_halt = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;

  logic        cpu_en, bp_hit, step_done;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        w4_en, w4_bp_hit, w4_step_done;
  logic [1:0]  w4_state;
  logic [3:0]  w4_cc;

  cpu_exec_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(32), .XLEN(32)) dut (
    .clk_out(clk_out), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .btn_halt(btn_halt), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .step_done(step_done),
    .cycle_count(cycle_count)
  );

  cpu_exec_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .XLEN(32)) dut_w4 (
    .clk_out(clk_out), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .btn_halt(btn_halt), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(w4_en), .state(w4_state), .bp_hit(w4_bp_hit), .step_done(w4_step_done),
    .cycle_count(w4_cc)
  );

  always #5 clk_out = ~clk_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0]  st_m;       // 0 halt, 1 run, 2 step
  logic        bphit_m;
  logic        armed_m;    // a full RUN cycle has elapsed since entering RUN
  logic        en_m;
  logic        match_m;
  logic [2:0]  p_m;        // press pulses {halt, step, run}
  logic [31:0] cnt_m;
  logic [2:0]  lvl_m;      // debounced levels
  logic [2:0]  prv_m;      // debounced levels one edge earlier
  logic [2:0]  raw_q[$];   // raw button samples taken at each edge since reset
  logic [2:0]  syn_q[$];   // synchronised samples consumed by the debouncer
  logic        auto_pc = 1'b0;
  logic [31:0] pc_mask = 32'hFFFF_FFFF;

  logic [45:0] obs_v, exp_v;
  assign obs_v = {cpu_en, state, bp_hit, step_done, cycle_count,
                  w4_en, w4_state, w4_bp_hit, w4_step_done, w4_cc};

  task automatic model_reset();
    st_m = 2'd0; bphit_m = 1'b0; armed_m = 1'b0; en_m = 1'b0; match_m = 1'b0;
    p_m = 3'b000; cnt_m = 32'd0; lvl_m = 3'b000; prv_m = 3'b000;
    raw_q.delete(); syn_q.delete();
  endtask

  // Let inputs settle and compute the expected outputs for the current cycle.
  task automatic eval();
    #1;
    p_m     = lvl_m & ~prv_m;
    match_m = bp_en && armed_m && (pc == bp_addr) && (st_m == 2'd1);
    en_m    = rst && (((st_m == 2'd1) && !match_m && !p_m[2]) || (st_m == 2'd2));
    exp_v   = {en_m, st_m, bphit_m, (st_m == 2'd2), cnt_m,
               en_m, st_m, bphit_m, (st_m == 2'd2), cnt_m[3:0]};
  endtask

  // Apply one clock edge to the model, then advance the simulation past it.
  task automatic adv();
    logic [1:0] nst;
    logic [2:0] synced, flip, smp;
    if (rst) begin
      case (st_m)
        2'd0:    nst = p_m[0] ? 2'd1 : (p_m[1] ? 2'd2 : 2'd0);
        2'd1:    nst = (p_m[2] || match_m) ? 2'd0 : 2'd1;
        default: nst = 2'd0;
      endcase
      if (st_m == 2'd0 && nst != 2'd0) bphit_m = 1'b0;
      if (st_m == 2'd1 && nst == 2'd0 && !p_m[2]) bphit_m = 1'b1;
      armed_m = (st_m == 2'd1) && (nst == 2'd1);
      if (en_m) cnt_m = cnt_m + 32'd1;
      st_m = nst;
      // Two flops of synchronisation: the debouncer sees the raw sample from two edges ago.
      synced = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 3'b000;
      syn_q.push_back(synced);
      flip = 3'b000;
      if (syn_q.size() >= D) begin
        for (int b = 0; b < 3; b++) begin
          flip[b] = 1'b1;
          for (int k = 0; k < D; k++) begin
            smp = syn_q[syn_q.size() - 1 - k];
            if (smp[b] == lvl_m[b]) flip[b] = 1'b0;
          end
        end
      end
      prv_m = lvl_m;
      lvl_m = lvl_m ^ flip;
      raw_q.push_back({btn_halt, btn_step, btn_run});
      while (raw_q.size() > 8) void'(raw_q.pop_front());
      while (syn_q.size() > 8) void'(syn_q.pop_front());
    end
    @(posedge clk_out);
    #1;
    if (auto_pc && en_m) pc = (pc + 32'd4) & pc_mask;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_v !== 46'd0) begin n_err++; $display("FAIL reset_async got=%h exp=%h", obs_v, 46'd0); end
    repeat (3) begin
      @(posedge clk_out);
      #1;
      n_vec++;
      if (obs_v !== 46'd0) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", obs_v, 46'd0); end
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      adv();
    end
  endtask

  task automatic test_glitch_run();
    int first_run = -1;
    for (int i = 0; i < 60; i++) begin
      btn_run  = (i < 3) || (i >= 20 && i < 30);
      btn_halt = (i >= 40 && i < 50);
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL glitch_run cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      if (state == 2'b01 && first_run < 0) first_run = i;
      adv();
    end
    btn_run = 1'b0; btn_halt = 1'b0;
    n_vec++;
    if (first_run < 25 || first_run > 27) begin
      n_err++; $display("FAIL run_latency first_run_cycle=%0d exp=25..27", first_run);
    end
  endtask

  task automatic test_step();
    int sd_cnt = 0;
    int en_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      btn_step = ((i % 20) < 10);
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL step cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      sd_cnt += int'(step_done);
      en_cnt += int'(cpu_en);
      adv();
    end
    btn_step = 1'b0;
    n_vec++;
    if (sd_cnt != 3 || en_cnt != 3 || state !== 2'b00) begin
      n_err++; $display("FAIL step_count step_done=%0d en=%0d state=%b exp=3,3,00", sd_cnt, en_cnt, state);
    end
  endtask

  task automatic test_breakpoint();
    logic [31:0] base = cnt_m;
    pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h0000_0010; auto_pc = 1'b1;
    for (int i = 0; i < 60; i++) begin
      btn_run  = (i < 10) || (i >= 25 && i < 35);
      btn_halt = (i >= 45 && i < 55);
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL breakpoint cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      if (i == 20) begin
        n_vec++;
        if ({state, bp_hit, pc} !== {2'b00, 1'b1, 32'h10} || cycle_count !== base + 32'd4) begin
          n_err++; $display("FAIL bp_halt st=%b hit=%b pc=%h cnt=%0d exp=00,1,10,%0d", state, bp_hit, pc, cycle_count, base + 32'd4);
        end
      end
      if (i == 40) begin
        n_vec++;
        if (state !== 2'b01 || bp_hit !== 1'b0 || pc <= 32'h10) begin
          n_err++; $display("FAIL bp_resume st=%b hit=%b pc=%h exp=01,0,>10", state, bp_hit, pc);
        end
      end
      adv();
    end
    btn_run = 1'b0; btn_halt = 1'b0; auto_pc = 1'b0; bp_en = 1'b0;
  endtask

  task automatic test_halt_run_together();
    for (int i = 0; i < 80; i++) begin
      btn_run  = (i < 10) || (i >= 20 && i < 30) || (i >= 40 && i < 50);
      btn_halt = (i >= 20 && i < 30) || (i >= 60 && i < 70);
      btn_step = (i >= 40 && i < 50);
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL halt_run cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      if (i == 26) begin
        n_vec++;
        if (cpu_en !== 1'b0 || state !== 2'b01) begin
          n_err++; $display("FAIL halt_suppress en=%b st=%b exp=0,01", cpu_en, state);
        end
      end
      if (i == 55) begin
        n_vec++;
        if (state !== 2'b01) begin n_err++; $display("FAIL run_step_together st=%b exp=01", state); end
      end
      adv();
    end
    btn_run = 1'b0; btn_halt = 1'b0; btn_step = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    rst = 1'b0;
    model_reset();
    adv(); adv();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      btn_run = (i < 10);
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      if (i == 24) begin
        n_vec++;
        if (cycle_count !== 32'd17 || w4_cc !== 4'd1) begin
          n_err++; $display("FAIL wrap_value cnt=%0d cnt4=%0d exp=17,1", cycle_count, w4_cc);
        end
      end
      adv();
    end
    btn_run = 1'b0;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_v !== 46'd0) begin n_err++; $display("FAIL reset_mid_run got=%h exp=%h", obs_v, 46'd0); end
    @(posedge clk_out);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      adv();
    end
  endtask

  task automatic test_random();
    int hold[3] = '{0, 0, 0};
    logic [2:0] lv = 3'b000;
    int rst_hold = 0;
    pc_mask = 32'h0000_003F; auto_pc = 1'b1; pc = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lv[b]   = (b == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
          hold[b] = $urandom_range(1, 14);
        end else begin
          hold[b]--;
        end
      end
      {btn_halt, btn_step, btn_run} = lv;
      if ($urandom_range(0, 99) == 0) begin
        bp_en   = ($urandom_range(0, 2) != 0);
        bp_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if ($urandom_range(0, 49) == 0) pc = 32'($urandom_range(0, 15)) << 2;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        model_reset();
        rst_hold = 2;
      end
      eval();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_v, exp_v); end
      adv();
    end
    rst = 1'b1; auto_pc = 1'b0;
    {btn_halt, btn_step, btn_run} = 3'b000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch_run();
    test_step();
    test_breakpoint();
    test_halt_run_together();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
